// File: rtl/mem_io_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_responder_pkg
// Shared definitions for the CPU-side memory/IO responder:
//   - IO window address constants (window base, UART data port, cycle counter)
//   - IO window decode width and select value
//   - byte typedef and the read-data source selector
// -----------------------------------------------------------------------------
package mem_io_responder_pkg;

  localparam int IO_ADDR_W = 18;  // decoded CPU address bits [17:0]
  localparam int IO_DEC_W  = 2;   // window select bits [17:16]

  localparam logic [IO_ADDR_W-1:0] IO_BASE = 18'h30000;
  localparam logic [IO_ADDR_W-1:0] IO_UART = 18'h30000;
  localparam logic [IO_ADDR_W-1:0] IO_CLK  = 18'h30004;

  localparam logic [IO_DEC_W-1:0] IO_SEL  = IO_BASE[IO_ADDR_W-1 -: IO_DEC_W];
  localparam logic [IO_DEC_W-1:0] ERR_SEL = 2'b10;

  typedef logic [7:0] byte_t;

  // Where the registered read byte comes from in the cycle after a request.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_t;

  function automatic logic is_io(input logic [IO_ADDR_W-1:0] a);
    return a[IO_ADDR_W-1 -: IO_DEC_W] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_io_tx_fifo.sv
// -----------------------------------------------------------------------------
// mem_io_tx_fifo
// Byte FIFO feeding the UART transmitter.
// Ports:
//   clk_in   clock
//   rst_in   synchronous active-low reset (empties the queue)
//   i_push   enqueue request; ignored when full
//   i_data   byte to enqueue
//   i_pop    dequeue request; ignored when empty
//   o_data   head byte (0 when empty)
//   o_count  number of stored bytes
//   o_full   count == DEPTH
//   o_empty  count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mem_io_tx_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   i_push,
  input  byte_t                  i_data,
  input  logic                   i_pop,
  output byte_t                  o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == DEPTH_C);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_count   = r_count;
  // Head reads as zero when empty so tx_data is clean out of reset.
  assign o_data    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
// Far-end responder of the CPU byte bus. Every clock is one bus access.
//   - 2^RAM_AW byte RAM for addr[17:16] != 2'b11; reads return next cycle
//   - IO window addr[17:16] == 2'b11:
//       0x30000 W: enqueue nonzero byte to UART TX queue (zero ignored)
//       0x30000 R: pop RX holding byte (0 if none)
//       0x30004 W: set stop flag and enqueue a 0x00 terminator
//       0x30004..7 R: cycle counter bytes; 0x30004 snapshots the counter
//   - prog_stop once stop is flagged and the TX queue has drained (sticky)
// Optional feature macro: MEM_IO_ADDR_CHECK_EN
//   defined   -> accesses to 0x20000-0x2FFFF set sticky addr_err, writes are
//                suppressed, reads return 0
//   undefined -> addr_err is 0 and those addresses alias into RAM
// Ports:
//   clk_in, rst_in (sync, active-low)
//   bus_a[31:0], bus_wr, bus_wdata[7:0] -> bus_rdata[7:0]
//   io_buffer_full               TX queue near full
//   tx_valid, tx_data, tx_ready  UART TX handshake
//   rx_valid, rx_data, rx_ready  UART RX handshake
//   prog_stop, addr_err          status
// -----------------------------------------------------------------------------
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        addr_err
);

  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  // One slot for a write already in flight, one reserved for the stop byte.
  localparam logic [CW-1:0] FULL_TH = CW'(TXQ_DEPTH - 2);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IO_ADDR_W-1:0] w_addr;
  logic [RAM_AW-1:0]    w_ram_idx;
  logic                 w_is_io;
  logic                 w_io_uart;
  logic                 w_io_clk;
  logic                 w_io_clk0;
  logic                 w_bad;
  logic                 w_unused;

  assign w_addr    = bus_a[IO_ADDR_W-1:0];
  assign w_ram_idx = bus_a[RAM_AW-1:0];
  assign w_is_io   = is_io(w_addr);
  assign w_io_uart = w_is_io && (w_addr == IO_UART);
  assign w_io_clk  = w_is_io && (w_addr[IO_ADDR_W-1:2] == IO_CLK[IO_ADDR_W-1:2]);
  assign w_io_clk0 = w_io_clk && (w_addr[1:0] == 2'b00);

`ifdef MEM_IO_ADDR_CHECK_EN
  assign w_bad = (w_addr[IO_ADDR_W-1 -: IO_DEC_W] == ERR_SEL);
`else
  assign w_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  byte_t       r_ram [0:(1<<RAM_AW)-1];
  byte_t       r_ram_q;
  byte_t       r_io_q;
  rd_src_t     r_src;
  logic [31:0] r_cycle;
  logic [31:0] r_snap;
  logic        r_stop;
  logic        r_stop_done;
  logic        r_rx_held;
  byte_t       r_rx_data;

  // ---------------------------------------------------------------------------
  // TX queue
  // ---------------------------------------------------------------------------
  logic          w_push;
  byte_t         w_push_data;
  logic          w_pop;
  byte_t         w_fifo_data;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // The stop write enqueues a literal zero; the zero filter only applies to
  // the UART data port.
  assign w_push      = bus_wr & ((w_io_uart & (bus_wdata != 8'h00)) | w_io_clk0);
  assign w_push_data = w_io_clk0 ? 8'h00 : bus_wdata;
  assign w_pop       = tx_valid & tx_ready;

  mem_io_tx_fifo #(
    .DEPTH (TXQ_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign tx_valid       = ~w_fifo_empty;
  assign tx_data        = w_fifo_data;
  assign io_buffer_full = (w_fifo_count >= FULL_TH);

  // Bits above the decoded range and the raw full flag are not needed here.
  assign w_unused = &{1'b0, bus_a[31:IO_ADDR_W], w_fifo_full};

  // ---------------------------------------------------------------------------
  // RX holding register
  // ---------------------------------------------------------------------------
  logic w_rx_load;
  logic w_rx_consume;

  assign rx_ready     = ~r_rx_held;
  assign w_rx_load    = rx_valid & ~r_rx_held;
  assign w_rx_consume = ~bus_wr & w_io_uart & r_rx_held;

  always_ff @(posedge clk_in) begin
    if (w_rx_load) r_rx_data <= rx_data;
  end

  // ---------------------------------------------------------------------------
  // RAM: write on the request edge, registered read
  // ---------------------------------------------------------------------------
  logic w_ram_we;

  assign w_ram_we = rst_in & bus_wr & ~w_is_io & ~w_bad;

  always_ff @(posedge clk_in) begin
    if (w_ram_we) r_ram[w_ram_idx] <= bus_wdata;
    r_ram_q <= r_ram[w_ram_idx];
  end

  // ---------------------------------------------------------------------------
  // IO read mux and read-source select
  // ---------------------------------------------------------------------------
  byte_t   w_io_rdata;
  rd_src_t w_src;

  always_comb begin
    w_io_rdata = '0;
    if (w_io_uart) begin
      w_io_rdata = r_rx_held ? r_rx_data : 8'h00;
    end else if (w_io_clk) begin
      // Byte 0 is live; bytes 1-3 come from the snapshot taken by the byte-0
      // read so a 4-read sequence forms one coherent dword.
      case (w_addr[1:0])
        2'd0:    w_io_rdata = r_cycle[7:0];
        2'd1:    w_io_rdata = r_snap[15:8];
        2'd2:    w_io_rdata = r_snap[23:16];
        default: w_io_rdata = r_snap[31:24];
      endcase
    end
  end

  always_comb begin
    w_src = SRC_ZERO;
    if (!bus_wr && !w_bad) begin
      w_src = w_is_io ? SRC_IO : SRC_RAM;
    end
  end

  always_ff @(posedge clk_in) begin
    r_io_q <= w_io_rdata;
  end

  always_comb begin
    bus_rdata = '0;
    case (r_src)
      SRC_RAM: bus_rdata = r_ram_q;
      SRC_IO:  bus_rdata = r_io_q;
      default: bus_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_src       <= SRC_ZERO;
      r_cycle     <= '0;
      r_snap      <= '0;
      r_stop      <= 1'b0;
      r_stop_done <= 1'b0;
      r_rx_held   <= 1'b0;
    end else begin
      r_src   <= w_src;
      r_cycle <= r_cycle + 32'd1;
      if (!bus_wr && w_io_clk0) r_snap <= r_cycle;
      if (bus_wr && w_io_clk0)  r_stop <= 1'b1;
      if (r_stop && w_fifo_empty) r_stop_done <= 1'b1;
      if (w_rx_consume) r_rx_held <= 1'b0;
      if (w_rx_load)    r_rx_held <= 1'b1;
    end
  end

  // Sticky once reached, even if the CPU enqueues more bytes afterwards.
  assign prog_stop = r_stop_done | (r_stop & w_fifo_empty);

  // ---------------------------------------------------------------------------
  // Address error flag
  // ---------------------------------------------------------------------------
`ifdef MEM_IO_ADDR_CHECK_EN
  logic r_addr_err;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_addr_err <= 1'b0;
    end else if (w_bad) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

endmodule
